sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/sprite_rom_arbiter.sv | 115 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_rom_pkg.sv
// rtl/sprite_rom_pkg.sv - shared FSM state type, default sizes and requester indices for the sprite ROM arbiter
package sprite_rom_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_LO = 2'd1,
    ADDR_HI = 2'd2,
    CAP_HI  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_NREQ   = 3;

  localparam int REQ_BALL  = 0;
  localparam int REQ_BAR_A = 1;
  localparam int REQ_BAR_B = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot winner select, round-robin after last-served
// Define SPRITE_ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no last-served input).
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant
`ifndef SPRITE_ROM_ARB_FIXED_PRIO_EN
  ,
  input  logic [IDX_W-1:0] last
`endif
);

  logic found;

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  // First pass covers indices above last-served, second pass wraps from 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j > int'(last))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shares a single-port 8-bit ROM among requesters, returning 16-bit words
// Define SPRITE_ROM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority.
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREQ   = DEF_NREQ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic [15:0]            rd_data,
  output logic [NREQ-1:0]        rd_valid,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [7:0]             rom_dout
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [NREQ-1:0]   win;
  logic [ADDR_W-1:0] win_addr;
  logic              grant_en;

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .grant (win)
  );
`else
  logic [IDX_W-1:0] last_served;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .grant (win),
    .last  (last_served)
  );

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst)           last_served <= IDX_W'(NREQ - 1);
    else if (grant_en) last_served <= oh2idx(win);
  end
`endif

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_addr = win_addr | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{win[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ADDR_LO;
      ADDR_LO: state_nxt = ADDR_HI;
      ADDR_HI: state_nxt = CAP_HI;
      CAP_HI:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    grant_en = (state == IDLE) && (|req);
  end

  // rom_addr itself carries the base, so the high-byte address is just rom_addr+1 (wraps).
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      rd_valid <= '0;
      rom_addr <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_en) begin
            gnt      <= win;
            rom_addr <= win_addr;
          end
        end
        ADDR_LO: rom_addr <= rom_addr + ADDR_W'(1);
        ADDR_HI: rd_data[7:0] <= rom_dout;
        CAP_HI: begin
          rd_data[15:8] <= rom_dout;
          rd_valid      <= gnt;
          gnt           <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter with a ROM model and reference arbiter
// Honours SPRITE_ROM_ARB_FIXED_PRIO_EN in its reference model.
module tb_sprite_rom_arbiter;

  localparam int AW = 11;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    gnt;
  logic             busy;
  logic [15:0]      rd_data;
  logic [NR-1:0]    rd_valid;
  logic [AW-1:0]    rom_addr;
  logic [7:0]       rom_dout;

  logic [7:0]       mem [0:(1<<AW)-1];
  logic [AW-1:0]    addr [NR];
  int               ref_last;
  int               n_assert = 0;
  int               n_fail = 0;
  int               order [4];
  int               w;

  always #5 clk = ~clk;

  sprite_rom_arbiter #(.ADDR_W(AW), .NREQ(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .busy     (busy),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  always @(posedge clk) rom_dout <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_addr();
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = addr[i];
  endtask

  function automatic int pick(input logic [NR-1:0] r);
    logic [NR-1:0] m;
`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) begin
      m = NR'(1) << i;
      if ((r & m) != '0) return i;
    end
`else
    for (int k = 1; k <= NR; k++) begin
      m = NR'(1) << ((ref_last + k) % NR);
      if ((r & m) != '0) return (ref_last + k) % NR;
    end
`endif
    return -1;
  endfunction

  // Called at a negedge with the DUT idle and req non-zero; returns at the rd_valid negedge.
  task automatic run_one(input bit mutate, input int drop_pct, output int winner);
    int            cnt;
    logic [AW-1:0] b;
    logic [AW-1:0] b1;
    logic [15:0]   exp_d;
    logic [NR-1:0] oh;
    winner = pick(req);
    oh     = NR'(1) << winner;
    b      = addr[2'(winner)];
    b1     = AW'((int'(b) + 1) % (1 << AW));
    exp_d  = {mem[b1], mem[b]};
    ref_last = winner;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        chk("gnt_owner", 32'(gnt), 32'(oh));
        chk("busy_high", 32'(busy), 32'd1);
        if (mutate) begin
          for (int i = 0; i < NR; i++) addr[i] = AW'($urandom_range(0, (1 << AW) - 1));
          drive_addr();
          if ($urandom_range(0, 99) < drop_pct) req = req & ~oh;
        end
      end
    end while (rd_valid == '0 && cnt < 12);
    chk("latency", 32'(cnt), 32'd4);
    chk("rd_valid", 32'(rd_valid), 32'(oh));
    chk("rd_data", 32'(rd_data), 32'(exp_d));
    chk("busy_gap", 32'(busy), 32'd0);
    chk("gnt_clear", 32'(gnt), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    for (int i = 0; i < NR; i++) addr[i] = '0;
    drive_addr();
    rst = 1'b1;
    req = '0;
    ref_last = NR - 1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    // Single request
    mem[11'h010] = 8'h34;
    mem[11'h011] = 8'h12;
    addr[0] = 11'h010;
    drive_addr();
    req = 3'b001;
    run_one(1'b0, 0, w);
    chk("single_data", 32'(rd_data), 32'h1234);
    req = '0;

    // Address wrap at top of ROM
    mem[11'h7FF] = 8'hCD;
    mem[11'h000] = 8'hAB;
    addr[1] = 11'h7FF;
    drive_addr();
    req = 3'b010;
    run_one(1'b0, 0, w);
    chk("wrap_data", 32'(rd_data), 32'hABCD);
    req = '0;
    repeat (3) @(negedge clk);
    chk("hold_data", 32'(rd_data), 32'hABCD);
    chk("hold_idle", 32'(busy), 32'd0);

    // Address change and req drop while in flight
    addr[0] = 11'h010;
    drive_addr();
    req = 3'b001;
    run_one(1'b1, 100, w);
    chk("midchange_data", 32'(rd_data), 32'h1234);
    chk("midchange_req", 32'(req), 32'd0);

    // Contention from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_last = NR - 1;
    req = 3'b111;
    for (int t = 0; t < 4; t++) run_one(1'b0, 0, order[t]);
`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
    chk("order_0", 32'(order[0]), 32'd0);
    chk("order_1", 32'(order[1]), 32'd0);
    chk("order_2", 32'(order[2]), 32'd0);
    chk("order_3", 32'(order[3]), 32'd0);
`else
    chk("order_0", 32'(order[0]), 32'd0);
    chk("order_1", 32'(order[1]), 32'd1);
    chk("order_2", 32'(order[2]), 32'd2);
    chk("order_3", 32'(order[3]), 32'd0);
`endif

    // Back-to-back from requester 0
    req = 3'b001;
    run_one(1'b0, 0, w);
    run_one(1'b0, 0, w);
    req = '0;
    @(negedge clk);

    // Reset abort in ADDR_HI
    addr[2] = AW'($urandom_range(0, (1 << AW) - 1));
    drive_addr();
    req = 3'b100;
    @(negedge clk);
    chk("abort_lo_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    chk("abort_hi_valid", 32'(rd_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rd_valid), 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd0);
    rst = 1'b0;
    ref_last = NR - 1;
    run_one(1'b0, 0, w);
    chk("abort_regrant", 32'(w), 32'd2);
    req = '0;

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      req = req | NR'($urandom_range(0, 7));
      if (req == '0) req = NR'($urandom_range(1, 7));
      run_one(1'b1, 30, w);
      if ($urandom_range(0, 3) == 0) req = req & ~(NR'(1) << w);
    end
    req = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
